// File: rtl/axi_lite_pkg.sv
// Shared constants and types for the AXI4-lite scratch memory responder.
package axi_lite_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ADDR_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Any byte-address bit at or above the window width means the access misses the memory.
  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                             input int unsigned       awidth);
    return (addr >> awidth) != '0;
  endfunction

endpackage

// File: rtl/axi_lite_slave_ram.sv
// Word RAM with one byte-enabled write port and one read-first synchronous read port.
module axi_lite_slave_ram
  import axi_lite_pkg::*;
#(
  parameter int unsigned AWIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STRB_W-1:0]      we_i,
  input  logic [AWIDTH-3:0]      waddr_i,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic                   re_i,
  input  logic                   rzero_i,
  input  logic [AWIDTH-3:0]      raddr_i,
  output logic [DATA_W-1:0]      rdata_o
);

  localparam int unsigned IW    = AWIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IW;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  // Non-blocking read of the array gives the pre-write value on a same-word collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-lite responder over a byte-strobed word RAM: independent AW/W holding regs, one outstanding read.
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int unsigned AWIDTH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic [2:0]        axi_awprot,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  input  logic [DATA_W-1:0] axi_wdata,
  input  logic [STRB_W-1:0] axi_wstrb,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  output logic [1:0]        axi_bresp,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  input  logic [ADDR_W-1:0] axi_araddr,
  input  logic [2:0]        axi_arprot,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  output logic [DATA_W-1:0] axi_rdata,
  output logic [1:0]        axi_rresp
);

  localparam int unsigned IW = AWIDTH - 2;

  logic              aw_held_q, aw_held_d;
  logic              aw_oor_q, aw_oor_d;
  logic [IW-1:0]     aw_idx_q, aw_idx_d;
  logic              w_held_q, w_held_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;

  r_state_e          r_state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;

  logic              commit_c;
  logic [STRB_W-1:0] ram_we_c;
  logic              ar_hs_c;
  logic              ar_oor_c;
  logic              unused_ok;

  assign unused_ok = ^{axi_awprot, axi_arprot};

  // A commit waits for both halves and for the previous response to drain.
  assign commit_c = aw_held_q & w_held_q & ~bvalid_q;
  assign ram_we_c = (commit_c && !aw_oor_q) ? wstrb_q : '0;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_oor_d  = aw_oor_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (commit_c) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_oor_q ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q && axi_bready) begin
      bvalid_d  = 1'b0;
    end

    if (axi_awvalid && awready_q) begin
      aw_held_d = 1'b1;
      aw_idx_d  = axi_awaddr[AWIDTH-1:2];
      aw_oor_d  = addr_out_of_range(axi_awaddr, AWIDTH);
    end

    if (axi_wvalid && wready_q) begin
      w_held_d  = 1'b1;
      wdata_d   = axi_wdata;
      wstrb_d   = axi_wstrb;
    end

    awready_d = ~aw_held_d;
    wready_d  = ~w_held_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      aw_oor_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      aw_oor_q  <= aw_oor_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign ar_hs_c  = (r_state_q == R_IDLE) && axi_arvalid;
  assign ar_oor_c = addr_out_of_range(axi_araddr, AWIDTH);

  // Read channel: data is captured in the RAM on the AR handshake and held until rready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (axi_arvalid) begin
            r_state_q <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rresp_q   <= ar_oor_c ? RESP_SLVERR : RESP_OKAY;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
          end
        end
        default: begin
          r_state_q <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  axi_lite_slave_ram #(
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we_c),
    .waddr_i (aw_idx_q),
    .wdata_i (wdata_q),
    .re_i    (ar_hs_c),
    .rzero_i (ar_oor_c),
    .raddr_i (axi_araddr[AWIDTH-1:2]),
    .rdata_o (axi_rdata)
  );

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rresp   = rresp_q;

endmodule
